mem_interface: RTL and testbench
================================

Name: mem_interface

Overview:
- Bus-side sink and memory responder for the LC-3 datapath.
- Captures the shared 16-bit datapath bus into MAR and MDR.
- Runs fixed-latency read and write cycles against on-chip memory, using MAR as the address and MDR as the write data.
- Returns read data into MDR, signals completion to the control FSM via R, and its MDR output feeds the bus mux's MDR source.

Parameters:
- WAIT_CYCLES, 2: number of cycles mem_en is held per access. Must be >= 1.
- Internal counter width is $clog2(WAIT_CYCLES+1).

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- bus_in  input  16  shared datapath bus value.
- LD_MAR  input  1  load MAR from bus_in.
- LD_MDR  input  1  load MDR; source is selected by MIO_EN.
- MIO_EN  input  1  0 = MDR source is bus_in; 1 = MDR source is the captured memory read data.
- MEM_RD  input  1  read request, level, held by the controller until R.
- MEM_WR  input  1  write request, level, held by the controller until R.
- mem_rdata  input  16  memory read data, valid on the last wait cycle.
- MAR  output  16  memory address register.
- MDR  output  16  memory data register.
- R  output  1  access complete (ready).
- mem_addr  output  16  memory address; equal to MAR.
- mem_wdata  output  16  memory write data; equal to MDR.
- mem_en  output  1  memory enable.
- mem_we  output  1  memory write enable.

Behaviour:
- Reset (sampled at the edge):
  - MAR=0, MDR=0, internal rdata_q=0, counter=0, state=IDLE.
  - Outputs R=0, mem_en=0, mem_we=0.
  - Reset overrides all other inputs.
  - Reset mid-access aborts the access: mem_en drops the next cycle, R is never asserted, and no write is guaranteed to complete.
- States: IDLE, RD_WAIT, WR_WAIT, DONE. Outputs are Moore-decoded from the state register:
  - RD_WAIT: mem_en=1, mem_we=0.
  - WR_WAIT: mem_en=1, mem_we=1.
  - DONE: R=1.
  - IDLE: all three 0.
- IDLE transitions:
  - MEM_WR=1 -> WR_WAIT, counter=0.
  - Else MEM_RD=1 -> RD_WAIT, counter=0.
  - MEM_WR and MEM_RD both high: write wins.
- RD_WAIT / WR_WAIT:
  - Counter increments each cycle.
  - When counter==WAIT_CYCLES-1, go to DONE.
  - On that RD_WAIT edge, rdata_q <= mem_rdata.
- DONE:
  - R held high.
  - Stay in DONE while MEM_RD or MEM_WR is high.
  - Go to IDLE on the first edge where both are low. This prevents retriggering.
  - R is high for at least one cycle.
- Latency:
  - Request sampled at edge k -> mem_en high for cycles k+1 .. k+WAIT_CYCLES.
  - R rises in cycle k+1+WAIT_CYCLES.
- MAR:
  - LD_MAR=1 -> MAR <= bus_in at the edge.
  - Ignored while in RD_WAIT or WR_WAIT, so the address is stable during an access.
- MDR:
  - LD_MDR=1 and MIO_EN=0 -> MDR <= bus_in.
  - LD_MDR=1 and MIO_EN=1 -> MDR <= rdata_q.
  - Ignored in WR_WAIT, so write data is stable.
  - Loads in IDLE, RD_WAIT and DONE are honoured.
  - A load with MIO_EN=1 in DONE after a read yields the new read data.
  - In RD_WAIT it yields the previous rdata_q.
- Simultaneous LD_MAR and LD_MDR in the same cycle: both registers update independently.
- Counter is always cleared on entry to a wait state, so there is no wrap-around.
- A request asserted while in DONE with the other request already held is treated as held: no new access starts until DONE exits to IDLE.

Test Plan:
- Reset: assert Reset 1 cycle with LD_MAR=1, bus_in=16'hFFFF -> MAR=0, MDR=0, R=0, mem_en=0.
- Register loads: bus_in=16'h3000 with LD_MAR -> MAR=16'h3000; bus_in=16'h1234 with LD_MDR, MIO_EN=0 -> MDR=16'h1234, mem_en stays 0.
- Read (WAIT_CYCLES=2):
  - Setup: MAR=16'h3000, mem_rdata=16'hBEEF, MEM_RD raised at edge k.
  - Response: mem_en=1, mem_we=0, mem_addr=16'h3000 in cycles k+1..k+2; R=1 from k+3.
  - Then LD_MDR with MIO_EN=1 -> MDR=16'hBEEF; drop MEM_RD -> R=0 next cycle.
- Write:
  - Setup: MDR=16'h00A5, MAR=16'h0010, MEM_WR raised.
  - Response: mem_we=1, mem_wdata=16'h00A5 for exactly 2 cycles.
  - LD_MDR with bus_in=16'hFFFF during WR_WAIT leaves mem_wdata at 16'h00A5; R then asserts.
- Hold and priority:
  - MEM_RD and MEM_WR high together -> mem_we=1 (write path).
  - Holding MEM_WR 5 cycles past R -> R stays 1 and mem_en stays 0, with no second access.
- Reset mid-read: Reset in cycle k+1 of a read -> mem_en=0 and R=0 next cycle, state=IDLE; a later read works normally.

Source files
------------

// File: rtl/mem_interface_if.sv
// Bus, memory and handshake signals between the LC-3 datapath/control
// logic and the memory interface block. The slave view belongs to
// mem_interface. The master view belongs to whoever drives the bus and
// requests, and services the memory.
interface mem_interface_if;
    logic [15:0] bus_in;
    logic        LD_MAR;
    logic        LD_MDR;
    logic        MIO_EN;
    logic        MEM_RD;
    logic        MEM_WR;
    logic [15:0] mem_rdata;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic        R;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_en;
    logic        mem_we;

    modport slave (
        input  bus_in, LD_MAR, LD_MDR, MIO_EN, MEM_RD, MEM_WR, mem_rdata,
        output MAR, MDR, R, mem_addr, mem_wdata, mem_en, mem_we
    );

    modport master (
        output bus_in, LD_MAR, LD_MDR, MIO_EN, MEM_RD, MEM_WR, mem_rdata,
        input  MAR, MDR, R, mem_addr, mem_wdata, mem_en, mem_we
    );
endinterface

// File: rtl/mem_interface.sv
// LC-3 memory interface: captures the datapath bus into MAR/MDR and runs
// fixed-latency read/write cycles against on-chip memory. R tells the
// control FSM that the access has finished. R stays high until both
// requests drop, so a held request cannot retrigger an access.
module mem_interface #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic            Clk,
    input  logic            Reset,
    mem_interface_if.slave  mif
);
    localparam int            CW       = $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);
    localparam logic [CW-1:0] ZERO_CNT = CW'(0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] cnt_r;
    logic [15:0]   mar_r;
    logic [15:0]   mdr_r;
    logic [15:0]   rdata_r;
    logic          last_s;
    logic          mem_en_s;
    logic          mem_we_s;
    logic          ready_s;

    assign last_s = (cnt_r == LAST_CNT);

    // State register; reset aborts any access in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: write has priority over read, and DONE waits for both requests to drop.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (mif.MEM_WR) begin
                    state_s = WR_WAIT;
                end else if (mif.MEM_RD) begin
                    state_s = RD_WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_WAIT: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RD_WAIT;
                end
            end
            WR_WAIT: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = WR_WAIT;
                end
            end
            DONE: begin
                if (!mif.MEM_RD && !mif.MEM_WR) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Moore output decode; the outputs depend only on the state register.
    always_comb begin
        mem_en_s = 1'b0;
        mem_we_s = 1'b0;
        ready_s  = 1'b0;
        case (state_r)
            IDLE: begin
                mem_en_s = 1'b0;
            end
            RD_WAIT: begin
                mem_en_s = 1'b1;
            end
            WR_WAIT: begin
                mem_en_s = 1'b1;
                mem_we_s = 1'b1;
            end
            DONE: begin
                ready_s = 1'b1;
            end
            default: begin
                ready_s = 1'b0;
            end
        endcase
    end

    // Wait counter: IDLE holds it at zero so every access starts counting from zero.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_r <= ZERO_CNT;
        end else begin
            case (state_r)
                RD_WAIT, WR_WAIT: cnt_r <= cnt_r + ONE_CNT;
                default:          cnt_r <= ZERO_CNT;
            endcase
        end
    end

    // Datapath registers: read-data capture on the last read cycle, and MAR/MDR loads frozen while memory uses them.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rdata_r <= 16'h0000;
            mar_r   <= 16'h0000;
            mdr_r   <= 16'h0000;
        end else begin
            if ((state_r == RD_WAIT) && last_s) begin
                rdata_r <= mif.mem_rdata;
            end
            if (mif.LD_MAR && (state_r != RD_WAIT) && (state_r != WR_WAIT)) begin
                mar_r <= mif.bus_in;
            end
            if (mif.LD_MDR && (state_r != WR_WAIT)) begin
                mdr_r <= mif.MIO_EN ? rdata_r : mif.bus_in;
            end
        end
    end

    assign mif.MAR       = mar_r;
    assign mif.MDR       = mdr_r;
    assign mif.mem_addr  = mar_r;
    assign mif.mem_wdata = mdr_r;
    assign mif.R         = ready_s;
    assign mif.mem_en    = mem_en_s;
    assign mif.mem_we    = mem_we_s;
endmodule

// File: tb/tb_mem_interface.sv
// Directed bench for mem_interface (WAIT_CYCLES=2). A scoreboard queue holds
// the expected data for each access. The entry is pushed when the request
// is issued and popped when the access completes.
module tb_mem_interface;
    logic Clk;
    logic Reset;
    int   total;
    int   bad;
    int   en_cnt;
    int   we_cnt;
    logic got_r;
    logic [15:0] sb_q[$];
    logic [15:0] exp_v;

    mem_interface_if mif ();

    mem_interface #(.WAIT_CYCLES(2)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .mif   (mif)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Reset = 1'b1;
        mif.bus_in    = 16'hFFFF;
        mif.LD_MAR    = 1'b1;
        mif.LD_MDR    = 1'b0;
        mif.MIO_EN    = 1'b0;
        mif.MEM_RD    = 1'b0;
        mif.MEM_WR    = 1'b0;
        mif.mem_rdata = 16'h0000;

        // Reset wins over a simultaneous MAR load.
        step();
        check("rst_mar", mif.MAR, 16'h0000);
        check("rst_mdr", mif.MDR, 16'h0000);
        check("rst_r", {15'd0, mif.R}, 16'h0000);
        check("rst_en", {15'd0, mif.mem_en}, 16'h0000);
        check("rst_we", {15'd0, mif.mem_we}, 16'h0000);
        Reset = 1'b0;

        // Register loads from the bus.
        mif.bus_in = 16'h3000;
        step();
        check("ld_mar", mif.MAR, 16'h3000);
        check("ld_mar_addr", mif.mem_addr, 16'h3000);
        mif.LD_MAR = 1'b0;
        mif.LD_MDR = 1'b1;
        mif.bus_in = 16'h1234;
        step();
        check("ld_mdr", mif.MDR, 16'h1234);
        check("ld_mdr_wdata", mif.mem_wdata, 16'h1234);
        check("ld_mdr_en", {15'd0, mif.mem_en}, 16'h0000);
        mif.LD_MAR = 1'b1;
        mif.bus_in = 16'h5555;
        step();
        check("ld_both_mar", mif.MAR, 16'h5555);
        check("ld_both_mdr", mif.MDR, 16'h5555);
        mif.LD_MDR = 1'b0;
        mif.bus_in = 16'h3000;
        step();
        mif.LD_MAR = 1'b0;

        // Read with explicit cycle-by-cycle timing.
        mif.mem_rdata = 16'hBEEF;
        mif.MEM_RD    = 1'b1;
        sb_q.push_back(16'hBEEF);
        step();
        check("rd_en_k1", {15'd0, mif.mem_en}, 16'h0001);
        check("rd_we_k1", {15'd0, mif.mem_we}, 16'h0000);
        check("rd_addr_k1", mif.mem_addr, 16'h3000);
        check("rd_r_k1", {15'd0, mif.R}, 16'h0000);
        mif.LD_MAR = 1'b1;
        mif.bus_in = 16'h4444;
        mif.LD_MDR = 1'b1;
        mif.MIO_EN = 1'b1;
        step();
        check("rd_en_k2", {15'd0, mif.mem_en}, 16'h0001);
        check("rd_mar_hold", mif.MAR, 16'h3000);
        check("rd_mdr_old", mif.MDR, 16'h0000);
        check("rd_r_k2", {15'd0, mif.R}, 16'h0000);
        mif.LD_MAR = 1'b0;
        mif.LD_MDR = 1'b0;
        mif.MIO_EN = 1'b0;
        step();
        check("rd_r_k3", {15'd0, mif.R}, 16'h0001);
        check("rd_en_k3", {15'd0, mif.mem_en}, 16'h0000);
        mif.LD_MDR = 1'b1;
        mif.MIO_EN = 1'b1;
        step();
        exp_v = sb_q.pop_front();
        check("rd_mdr_data", mif.MDR, exp_v);
        check("rd_r_held", {15'd0, mif.R}, 16'h0001);
        mif.LD_MDR = 1'b0;
        mif.MIO_EN = 1'b0;
        mif.MEM_RD = 1'b0;
        step();
        check("rd_r_drop", {15'd0, mif.R}, 16'h0000);

        // Write: an MDR load during the access must not disturb the write data.
        mif.LD_MAR = 1'b1;
        mif.bus_in = 16'h0010;
        step();
        mif.LD_MAR = 1'b0;
        mif.LD_MDR = 1'b1;
        mif.bus_in = 16'h00A5;
        step();
        mif.LD_MDR = 1'b0;
        sb_q.push_back(16'h00A5);
        mif.MEM_WR = 1'b1;
        we_cnt = 0;
        got_r  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (mif.R) begin
                got_r = 1'b1;
                break;
            end
            if (mif.mem_we) begin
                we_cnt++;
                check("wr_wdata", mif.mem_wdata, sb_q[0]);
                check("wr_addr", mif.mem_addr, 16'h0010);
            end
            mif.LD_MDR = (we_cnt == 1) ? 1'b1 : 1'b0;
            mif.bus_in = 16'hFFFF;
        end
        mif.LD_MDR = 1'b0;
        check("wr_done", {15'd0, got_r}, 16'h0001);
        check("wr_we_cycles", 16'(we_cnt), 16'd2);
        exp_v = sb_q.pop_front();
        check("wr_mdr_kept", mif.MDR, exp_v);

        // A held write request keeps R high and must not start a second access.
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_r", {15'd0, mif.R}, 16'h0001);
            check("hold_en", {15'd0, mif.mem_en}, 16'h0000);
        end
        mif.MEM_WR = 1'b0;
        step();
        check("hold_r_drop", {15'd0, mif.R}, 16'h0000);

        // Read and write requested together: the write path wins.
        mif.MEM_RD = 1'b1;
        mif.MEM_WR = 1'b1;
        step();
        check("prio_we", {15'd0, mif.mem_we}, 16'h0001);
        check("prio_en", {15'd0, mif.mem_en}, 16'h0001);
        got_r = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (mif.R) begin
                got_r = 1'b1;
                break;
            end
        end
        check("prio_done", {15'd0, got_r}, 16'h0001);
        mif.MEM_RD = 1'b0;
        mif.MEM_WR = 1'b0;
        step();

        // Reset in the first wait cycle of a read aborts the access.
        mif.mem_rdata = 16'h1357;
        mif.MEM_RD    = 1'b1;
        step();
        check("abort_en_k1", {15'd0, mif.mem_en}, 16'h0001);
        Reset = 1'b1;
        step();
        check("abort_en", {15'd0, mif.mem_en}, 16'h0000);
        check("abort_r", {15'd0, mif.R}, 16'h0000);
        check("abort_mar", mif.MAR, 16'h0000);
        Reset      = 1'b0;
        mif.MEM_RD = 1'b0;
        step();
        check("abort_idle_en", {15'd0, mif.mem_en}, 16'h0000);
        check("abort_idle_r", {15'd0, mif.R}, 16'h0000);

        // A fresh read after the abort behaves normally.
        mif.LD_MAR = 1'b1;
        mif.bus_in = 16'h3000;
        step();
        mif.LD_MAR = 1'b0;
        sb_q.push_back(16'h1357);
        mif.MEM_RD = 1'b1;
        en_cnt = 0;
        got_r  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (mif.R) begin
                got_r = 1'b1;
                break;
            end
            if (mif.mem_en) begin
                en_cnt++;
            end
        end
        check("rd2_done", {15'd0, got_r}, 16'h0001);
        check("rd2_en_cycles", 16'(en_cnt), 16'd2);
        mif.LD_MDR = 1'b1;
        mif.MIO_EN = 1'b1;
        step();
        exp_v = sb_q.pop_front();
        check("rd2_mdr_data", mif.MDR, exp_v);
        mif.LD_MDR = 1'b0;
        mif.MIO_EN = 1'b0;
        mif.MEM_RD = 1'b0;
        step();
        check("rd2_r_drop", {15'd0, mif.R}, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
